// File: rtl/cap_sense_if.sv
// Signal bundle between one capacitive pad driver and its counter, pad and game logic.
// master = the driver; slave = the surrounding logic that feeds it and consumes its results.
interface cap_sense_if;
  logic        enable;
  logic        sensor_in;
  logic [31:0] final_count;
  logic        pin_oe;
  logic        pin_drive;
  logic        start;
  logic        capacitor_charged;
  logic [31:0] sample;
  logic        sample_valid;
  logic        timeout;
  logic [31:0] baseline;
  logic        calibrated;
  logic        touched;

  modport master (
    input  enable, sensor_in, final_count,
    output pin_oe, pin_drive, start, capacitor_charged,
    output sample, sample_valid, timeout, baseline, calibrated, touched
  );

  modport slave (
    output enable, sensor_in, final_count,
    input  pin_oe, pin_drive, start, capacitor_charged,
    input  sample, sample_valid, timeout, baseline, calibrated, touched
  );
endinterface

// File: rtl/cap_sense_driver.sv
// Charge/release sequencer for one capacitive pad: captures the discharge count,
// builds a baseline from the first samples and reports a hysteretic touch flag.
module cap_sense_driver #(
  parameter int CHARGE_CYCLES  = 500,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int IDLE_CYCLES    = 5000,
  parameter int CAL_SAMPLES    = 16,
  parameter int THRESHOLD      = 200
) (
  input logic         clock,
  input logic         reset,
  cap_sense_if.master bus
);

  localparam int          CAL_SH       = $clog2(CAL_SAMPLES);
  localparam int          ACC_W        = 32 + CAL_SH;
  localparam logic [31:0] IDLE_LAST    = 32'(IDLE_CYCLES - 1);
  localparam logic [31:0] CHARGE_LAST  = 32'(CHARGE_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_VAL  = 32'(TIMEOUT_CYCLES);
  localparam logic [CAL_SH-1:0] CAL_LAST = CAL_SH'(CAL_SAMPLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_CHARGE, S_SENSE, S_CAPTURE} state_t;

  state_t             state;
  logic [31:0]        cnt;
  logic               timed_out;
  logic [ACC_W-1:0]   cal_acc;
  logic [CAL_SH-1:0]  cal_cnt;

  logic [31:0]        cap_val;
  logic               accept;
  logic [ACC_W-1:0]   acc_next;

  // Hysteresis: set at or above base+THRESHOLD (or on a timeout), clear below base+THRESHOLD/2.
  function automatic logic touch_next(input logic cur, input logic [31:0] s,
                                      input logic [31:0] base, input logic to);
    logic [32:0] hi;
    logic [32:0] lo;
    hi = {1'b0, base} + 33'(THRESHOLD);
    lo = {1'b0, base} + 33'(THRESHOLD / 2);
    if (to || ({1'b0, s} >= hi)) return 1'b1;
    if ({1'b0, s} < lo) return 1'b0;
    return cur;
  endfunction

  always_comb begin
    cap_val  = timed_out ? TIMEOUT_VAL : bus.final_count;
    accept   = timed_out || (bus.final_count != 32'd0);
    acc_next = cal_acc + ACC_W'(cap_val);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state                 <= S_IDLE;
      cnt                   <= '0;
      timed_out             <= 1'b0;
      cal_acc               <= '0;
      cal_cnt               <= '0;
      bus.pin_oe            <= 1'b1;
      bus.pin_drive         <= 1'b0;
      bus.start             <= 1'b0;
      bus.capacitor_charged <= 1'b0;
      bus.sample            <= '0;
      bus.sample_valid      <= 1'b0;
      bus.timeout           <= 1'b0;
      bus.baseline          <= '0;
      bus.calibrated        <= 1'b0;
      bus.touched           <= 1'b0;
    end else begin
      bus.sample_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          // Counter saturates while disabled so a later enable starts charging at once.
          if (cnt >= IDLE_LAST) begin
            if (bus.enable) begin
              state         <= S_CHARGE;
              cnt           <= '0;
              bus.pin_drive <= 1'b1;
              bus.start     <= 1'b1;
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_CHARGE: begin
          if (cnt == CHARGE_LAST) begin
            state                 <= S_SENSE;
            cnt                   <= '0;
            bus.pin_oe            <= 1'b0;
            bus.pin_drive         <= 1'b0;
            bus.capacitor_charged <= 1'b1;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_SENSE: begin
          // A discharge seen on the last allowed cycle still counts as a real sample.
          if (!bus.sensor_in || (cnt == TIMEOUT_LAST)) begin
            state                 <= S_CAPTURE;
            cnt                   <= '0;
            timed_out             <= bus.sensor_in;
            bus.capacitor_charged <= 1'b0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_CAPTURE: begin
          state      <= S_IDLE;
          cnt        <= '0;
          bus.pin_oe <= 1'b1;
          bus.start  <= 1'b0;
          if (accept) begin
            bus.sample       <= cap_val;
            bus.timeout      <= timed_out;
            bus.sample_valid <= 1'b1;
            if (bus.calibrated) begin
              bus.touched <= touch_next(bus.touched, cap_val, bus.baseline, timed_out);
            end else if (!timed_out) begin
              cal_acc <= acc_next;
              cal_cnt <= cal_cnt + CAL_SH'(1);
              if (cal_cnt == CAL_LAST) begin
                bus.baseline   <= acc_next[CAL_SH +: 32];
                bus.calibrated <= 1'b1;
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cap_sense_driver.sv
// Directed bench for cap_sense_driver: literal checks on each scenario plus a
// per-cycle timeline/scoreboard model of the measurement and calibration rules.
module tb_cap_sense_driver;

  localparam int CHARGE_C  = 4;
  localparam int IDLE_C    = 3;
  localparam int TIMEOUT_C = 50;
  localparam int CAL_N     = 4;
  localparam int THR       = 20;

  logic clock;
  logic reset;
  cap_sense_if bus();

  cap_sense_driver #(
    .CHARGE_CYCLES (CHARGE_C),
    .TIMEOUT_CYCLES(TIMEOUT_C),
    .IDLE_CYCLES   (IDLE_C),
    .CAL_SAMPLES   (CAL_N),
    .THRESHOLD     (THR)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: measurement timeline by absolute cycle numbers, samples by plain arithmetic.
  int          cyc = 0;
  bit          mvalid = 0;
  int          idle_since, cs, cap;
  bit          m_to;
  logic [31:0] e_sample, e_base;
  bit          e_sv, e_to, e_cal, e_touch;
  longint      cal_sum;
  int          cal_n;

  initial begin
    forever begin
      @(posedge clock);
      #1;
      e_sv = 0;
      if (reset) begin
        mvalid = 1; idle_since = cyc + 1; cs = -1; cap = -1; m_to = 0;
        e_sample = 0; e_base = 0; e_to = 0; e_cal = 0; e_touch = 0;
        cal_sum = 0; cal_n = 0;
      end else if (mvalid) begin
        if (cs < 0) begin
          if ((cyc - idle_since + 1 >= IDLE_C) && bus.enable) cs = cyc + 1;
        end else if (cyc == cap) begin
          longint v;
          bit     was_cal;
          v = m_to ? longint'(TIMEOUT_C) : longint'(bus.final_count);
          if (m_to || bus.final_count != 0) begin
            was_cal  = e_cal;
            e_sv     = 1;
            e_sample = 32'(v);
            e_to     = m_to;
            if (was_cal) begin
              if (m_to || v >= longint'(e_base) + THR) e_touch = 1;
              else if (v < longint'(e_base) + THR / 2) e_touch = 0;
            end else if (!m_to) begin
              cal_sum += v;
              cal_n++;
              if (cal_n == CAL_N) begin
                e_base = 32'(cal_sum / CAL_N);
                e_cal  = 1;
              end
            end
          end
          idle_since = cyc + 1; cs = -1; cap = -1;
        end else if (cyc >= cs + CHARGE_C && cap < 0) begin
          if (!bus.sensor_in) begin
            cap = cyc + 1; m_to = 0;
          end else if (cyc - (cs + CHARGE_C) + 1 == TIMEOUT_C) begin
            cap = cyc + 1; m_to = 1;
          end
        end
      end
      cyc++;
      if (mvalid) begin
        bit idle, chg, capt, sns;
        idle = (cs < 0) || (cyc < cs);
        chg  = !idle && (cyc < cs + CHARGE_C);
        capt = (cap == cyc);
        sns  = !idle && !chg && !capt;
        chk("mdl_start", bus.start, !idle);
        chk("mdl_cc", bus.capacitor_charged, sns);
        if (idle || chg) begin
          chk("mdl_oe", bus.pin_oe, 1);
          chk("mdl_drive", bus.pin_drive, chg);
        end else if (sns) begin
          chk("mdl_oe", bus.pin_oe, 0);
        end
        chk("mdl_sample", bus.sample, e_sample);
        chk("mdl_sv", bus.sample_valid, e_sv);
        chk("mdl_timeout", bus.timeout, e_to);
        chk("mdl_baseline", bus.baseline, e_base);
        chk("mdl_cal", bus.calibrated, e_cal);
        chk("mdl_touched", bus.touched, e_touch);
      end
    end
  end

  task automatic wait_cc(input string nm);
    int n = 0;
    while (bus.capacitor_charged !== 1'b1 && n < 400) begin
      @(negedge clock);
      n++;
    end
    chk(nm, 32'(n < 400), 1);
  endtask

  // One measurement. d<0: sensor stays high (timeout); else sensor drops on SENSE cycle d.
  task automatic meas(input int d, input logic [31:0] fc, input bit in_sense, input bit pulse,
                      input logic [31:0] es, input bit eto, input bit etouch,
                      input bit ecal, input logic [31:0] ebase);
    int n;
    bus.final_count = fc;
    bus.sensor_in   = 1'b1;
    if (!in_sense) wait_cc("wait_sense");
    if (d < 0) begin
      n = 0;
      while (bus.capacitor_charged === 1'b1 && n < TIMEOUT_C + 5) begin
        n++;
        @(negedge clock);
      end
      chk("sense_len_to", n, 50);
    end else begin
      repeat (d) @(negedge clock);
      chk("pre_low_cc", bus.capacitor_charged, 1);
      bus.sensor_in = 1'b0;
      @(negedge clock);
    end
    chk("cap_cc", bus.capacitor_charged, 0);
    chk("cap_start", bus.start, 1);
    chk("cap_sv", bus.sample_valid, 0);
    @(negedge clock);
    chk("sv", bus.sample_valid, pulse);
    chk("sample", bus.sample, es);
    chk("timeout", bus.timeout, eto);
    chk("touched", bus.touched, etouch);
    chk("calibrated", bus.calibrated, ecal);
    chk("baseline", bus.baseline, ebase);
    @(negedge clock);
    chk("sv_end", bus.sample_valid, 0);
    bus.sensor_in = 1'b1;
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_oe"}, bus.pin_oe, 1);
    chk({pfx, "_drive"}, bus.pin_drive, 0);
    chk({pfx, "_start"}, bus.start, 0);
    chk({pfx, "_cc"}, bus.capacitor_charged, 0);
    chk({pfx, "_sample"}, bus.sample, 0);
    chk({pfx, "_sv"}, bus.sample_valid, 0);
    chk({pfx, "_to"}, bus.timeout, 0);
    chk({pfx, "_base"}, bus.baseline, 0);
    chk({pfx, "_cal"}, bus.calibrated, 0);
    chk({pfx, "_touch"}, bus.touched, 0);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    bus.enable = 1'b0;
    bus.sensor_in = 1'b1;
    bus.final_count = 32'd0;
    repeat (3) @(negedge clock);
    chk_reset_vals("rst");

    // Startup waveform: 3 idle, 4 charge, then released pad.
    reset = 1'b0;
    bus.enable = 1'b1;
    bus.final_count = 32'd10;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clock);
      chk("wf_start", bus.start, (i >= 3) ? 1 : 0);
      chk("wf_oe", bus.pin_oe, (i == 7) ? 0 : 1);
      chk("wf_cc", bus.capacitor_charged, (i == 7) ? 1 : 0);
      if (i < 7) chk("wf_drive", bus.pin_drive, (i >= 3) ? 1 : 0);
    end
    meas(10, 32'd10, 1, 1, 32'd10, 0, 0, 0, 32'd0);

    // Reset in the middle of SENSE.
    wait_cc("rst_wait");
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk_reset_vals("midrst");
    reset = 1'b0;

    meas(-1, 32'd7, 0, 1, 32'd50, 1, 0, 0, 32'd0);   // timeout, uncalibrated
    meas(2, 32'd0, 0, 0, 32'd50, 1, 0, 0, 32'd0);    // zero count discarded
    meas(3, 32'd100, 0, 1, 32'd100, 0, 0, 0, 32'd0);
    meas(5, 32'd102, 0, 1, 32'd102, 0, 0, 0, 32'd0);
    meas(1, 32'd98, 0, 1, 32'd98, 0, 0, 0, 32'd0);
    meas(0, 32'd100, 0, 1, 32'd100, 0, 0, 1, 32'd100);
    meas(4, 32'd125, 0, 1, 32'd125, 0, 1, 1, 32'd100);
    meas(4, 32'd112, 0, 1, 32'd112, 0, 1, 1, 32'd100);
    meas(4, 32'd109, 0, 1, 32'd109, 0, 0, 1, 32'd100);
    meas(-1, 32'd7, 0, 1, 32'd50, 1, 1, 1, 32'd100); // timeout forces touch
    meas(4, 32'd110, 0, 1, 32'd110, 0, 1, 1, 32'd100);
    meas(4, 32'd109, 0, 1, 32'd109, 0, 0, 1, 32'd100);
    meas(4, 32'd120, 0, 1, 32'd120, 0, 1, 1, 32'd100);

    // Drop enable during CHARGE: measurement completes, then the driver holds in IDLE.
    n = 0;
    while (bus.start !== 1'b1 && n < 400) begin
      @(negedge clock);
      n++;
    end
    chk("wait_charge", 32'(n < 400), 1);
    bus.enable = 1'b0;
    meas(4, 32'd105, 0, 1, 32'd105, 0, 0, 1, 32'd100);
    n = 0;
    repeat (30) begin
      @(negedge clock);
      if (bus.start !== 1'b0 || bus.capacitor_charged !== 1'b0) n++;
    end
    chk("hold_idle", n, 0);
    bus.enable = 1'b1;
    @(negedge clock);
    chk("resume_start", bus.start, 1);
    chk("resume_drive", bus.pin_drive, 1);
    repeat (3) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cap_sense_driver.md
# cap_sense_driver

Excitation and decision side of the capacitive touch channel. It charges the sensor pad and then releases it. It sequences the discharge counter's active-low `start` clear and its `capacitor_charged` qualifier, then captures the counter's `final_count`. From the first samples it builds a baseline, and it reports a debounced `touched` flag to game logic, one instance per mole pad.

## Interface
Parameters:
- `CHARGE_CYCLES`, 500: cycles the pad is driven high per measurement (≥1).
- `TIMEOUT_CYCLES`, 100000: maximum SENSE cycles before the measurement is aborted (≥1).
- `IDLE_CYCLES`, 5000: cycles the pad is held low between measurements (≥1).
- `CAL_SAMPLES`, 16: number of valid samples averaged into the baseline (power of two, 2..256).
- `THRESHOLD`, 200: a sample this far above the baseline counts as a touch (≥2).

Ports:
- `clock`, in, 1: system clock.
- `reset`, in, 1: synchronous, active-high.
- `enable`, in, 1: run measurements; sampled only in IDLE.
- `sensor_in`, in, 1: synchronized pad level.
- `final_count`, in, 32: latched discharge count from the counter.
- `pin_oe`, out, 1: pad output enable (1 = driven).
- `pin_drive`, out, 1: pad drive value.
- `start`, out, 1: active-low clear to the counter.
- `capacitor_charged`, out, 1: counter qualifier; high while the pad is released.
- `sample`, out, 32: last accepted measurement.
- `sample_valid`, out, 1: one-cycle pulse when `sample` updates.
- `timeout`, out, 1: the last measurement hit TIMEOUT_CYCLES.
- `baseline`, out, 32: calibrated untouched count.
- `calibrated`, out, 1: high once the baseline is valid.
- `touched`, out, 1: debounced touch state.

## Operation
- All outputs are registered. Reset values:
  - `pin_oe`=1, `pin_drive`=0, `start`=0, `capacitor_charged`=0.
  - `sample`=0, `sample_valid`=0, `timeout`=0, `baseline`=0, `calibrated`=0, `touched`=0.
  - State = IDLE, all counters 0, calibration accumulator 0.
- IDLE:
  - Pad driven low (oe=1, drive=0); `start`=0 holds the counter cleared.
  - After IDLE_CYCLES cycles, with `enable`=1, go to CHARGE. With `enable`=0, remain in IDLE and keep the idle counter saturated.
- CHARGE:
  - oe=1, drive=1, `start`=1, `capacitor_charged`=0.
  - After CHARGE_CYCLES cycles, go to SENSE.
- SENSE:
  - oe=0, `start`=1, `capacitor_charged`=1.
  - The first cycle with `sensor_in`=0 goes to CAPTURE.
  - If the SENSE cycle count reaches TIMEOUT_CYCLES first, go to CAPTURE with the timeout flag set.
  - If `sensor_in`=0 and the timeout occur in the same cycle, the discharge wins (timeout flag clear).
- CAPTURE:
  - One cycle; `capacitor_charged`=0, `start`=1.
  - Normal discharge: read `final_count`.
  - Timeout: take the sample value as TIMEOUT_CYCLES.
  - Next state IDLE.
- Sample acceptance:
  - A `final_count` of 0 on a non-timeout measurement is discarded: no pulse, and no output changes.
  - Otherwise, in the cycle after CAPTURE, update `sample` and `timeout` and pulse `sample_valid`.
- Calibration, while `calibrated`=0:
  - Add each accepted non-timeout sample to a (32+log2 CAL_SAMPLES)-bit accumulator.
  - After CAL_SAMPLES such samples, set `baseline` = accumulator >> log2(CAL_SAMPLES) and set `calibrated`=1.
  - Both update in the same cycle as the final `sample_valid`.
  - Timeout samples do not count toward calibration.
  - `touched` stays 0 until `calibrated`=1.
- Touch decision, evaluated on each `sample_valid` once calibrated, using 33-bit sums with no wrap:
  - Set `touched` when `sample` ≥ `baseline` + THRESHOLD, or when `timeout`=1.
  - Clear `touched` when `sample` < `baseline` + THRESHOLD/2.
  - In between, hold the current value.
- Reset mid-operation returns all state to reset values and restarts calibration from zero.

## Timing
- Measurement period = IDLE_CYCLES + CHARGE_CYCLES + S + 1 cycles, where S is the number of SENSE cycles (1..TIMEOUT_CYCLES).
- `start` rises on the first CHARGE cycle, at least CHARGE_CYCLES cycles before `capacitor_charged` rises.
- `capacitor_charged` rises in the same cycle that `pin_oe` falls.
- `final_count` is read in CAPTURE, one cycle after the SENSE cycle that saw `sensor_in`=0. This matches the counter's one-cycle latch.
- `sample_valid` comes one cycle after CAPTURE; `touched`, `baseline` and `calibrated` change only in that cycle.
- `enable` falling mid-measurement completes the current measurement, then holds in IDLE.

## Test plan
- Reset, then `enable`=1 with CHARGE_CYCLES=4, IDLE_CYCLES=3 -> `start`=0 and oe=1/drive=0 for 3 cycles, then drive=1 for 4 cycles, then oe=0 with `capacitor_charged`=1.
- Model `sensor_in` low 10 cycles into SENSE, `final_count`=10 -> CAPTURE next cycle, then `sample`=10 and a one-cycle `sample_valid`.
- CAL_SAMPLES=4, samples 100,102,98,100 -> `baseline`=100 and `calibrated`=1 on the fourth pulse; `touched`=0 throughout.
- After calibration with THRESHOLD=20: samples 125 -> `touched`=1; then 112 -> stays 1; then 109 -> 0.
- `sensor_in` held high, TIMEOUT_CYCLES=50 -> CAPTURE after 50 SENSE cycles, `sample`=50, `timeout`=1; `touched`=1 if calibrated, and calibration count unchanged if not.
- `final_count`=0 -> no `sample_valid`, outputs unchanged; separately, `reset` asserted during SENSE -> next cycle all outputs at reset values, `calibrated`=0.
